// File: rtl/sfr_pkg.sv
// Shared SFR definitions: register map and arbiter FSM encoding.
package sfr_pkg;

  // SFR register map; every address from SOUT upward is serial output.
  typedef enum logic [7:0] {
    NOP        = 8'd0,
    TMR0L,
    TMR0H,
    PWM_DT,
    PWM_PERIOD,
    PWM1_DUTY,
    PWM2_DUTY,
    PWM3_DUTY,
    ENC_PRSC,
    ENC,
    SOUT
  } sfr_addr_e;

  localparam int SOUT_ADDR_DFLT = int'(SOUT);

  // Arbiter sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    RECOVER,
    DONE_RD,
    ABORT
  } arb_state_e;

endpackage

// File: rtl/sfr_rr_pick.sv
// Two-way round-robin select: a lone request wins outright, a tie goes to
// the requester that was not served last.
module sfr_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

  assign valid  = req0 | req1;
  assign winner = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/sfr_bus_arbiter.sv
// Shares the single SFR port between the CPU core (0) and the debug/loader
// path (1). Every write is sequenced as setup / one-cycle strobe / recover so
// the SFR block sees settled addr/data around the write_valid rising edge.
// SOUT writes wait for the UART, with a bounded stall before aborting.
module sfr_bus_arbiter
  import sfr_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int SOUT_ADDR    = SOUT_ADDR_DFLT,
  parameter int SOUT_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [7:0]        wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [7:0]        wdata1,
  output logic              ack1,
  output logic [7:0]        rdata,
  output logic              err,
  output logic              busy,
  output logic              grant,
  input  logic              sout_busy,
  output logic [ADDR_W-1:0] sfr_addr,
  output logic [7:0]        sfr_write_val,
  output logic              sfr_write_valid,
  input  logic [7:0]        sfr_read_val
);

  localparam int                CNT_W   = (SOUT_TIMEOUT > 0) ? $clog2(SOUT_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SOUT_TIMEOUT);
  localparam logic [ADDR_W-1:0] SOUT_A  = ADDR_W'(SOUT_ADDR);

  arb_state_e       state, state_nx;
  logic             we_q;
  logic             last_q;
  logic             pick_vld, pick_win;
  logic             stall;
  logic             ack_nx;
  logic [CNT_W-1:0] cnt;

  sfr_rr_pick u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last_q),
    .valid  (pick_vld),
    .winner (pick_win)
  );

  // A write to the serial-output range must wait while the UART is busy.
  assign stall  = we_q & (sfr_addr >= SOUT_A) & sout_busy;
  assign ack_nx = (state_nx == RECOVER) | (state_nx == DONE_RD) | (state_nx == ABORT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; sout_busy only matters while holding in SETUP.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_vld) state_nx = SETUP;
      SETUP: begin
        if (!we_q)               state_nx = DONE_RD;
        else if (!stall)         state_nx = STROBE;
        else if (cnt == CNT_MAX) state_nx = ABORT;
      end
      STROBE:  state_nx = RECOVER;
      RECOVER: state_nx = IDLE;
      DONE_RD: state_nx = IDLE;
      ABORT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Transaction latch, stall counter and registered (glitch-free) outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sfr_addr        <= '0;
      sfr_write_val   <= '0;
      sfr_write_valid <= 1'b0;
      we_q            <= 1'b0;
      grant           <= 1'b0;
      last_q          <= 1'b1;   // so requester 0 wins the first tie
      cnt             <= '0;
      rdata           <= '0;
      ack0            <= 1'b0;
      ack1            <= 1'b0;
      err             <= 1'b0;
      busy            <= 1'b0;
    end else begin
      // SFR bus only changes on accept, so it holds steady through IDLE.
      if (state == IDLE && pick_vld) begin
        grant         <= pick_win;
        sfr_addr      <= pick_win ? addr1  : addr0;
        sfr_write_val <= pick_win ? wdata1 : wdata0;
        we_q          <= pick_win ? we1    : we0;
        cnt           <= '0;
      end
      if (state == SETUP && stall && cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
      if (state == SETUP && !we_q)
        rdata <= sfr_read_val;
      // Pointer moves away from whoever was just served.
      if (state == RECOVER || state == DONE_RD || state == ABORT)
        last_q <= grant;
      sfr_write_valid <= (state_nx == STROBE);
      ack0            <= ack_nx & ~grant;
      ack1            <= ack_nx &  grant;
      err             <= (state_nx == ABORT);
      busy            <= (state_nx != IDLE);
    end
  end

endmodule
